icache_linefill_ctrl: RTL and testbench

//  Downstream neighbour of the MSHR entries. It records each linefill request when that request leaves an MSHR entry.
//  It collects the downstream read-data beats for that line and assembles a full cache line.
//  It writes the line into the data RAM at the recorded index/way.

---
 rtl/icache_linefill_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_icache_linefill_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_linefill_ctrl.sv
// I-cache linefill controller: snoops MSHR linefill requests into a slot table,
// assembles downstream beats into a full line, writes it to the data RAM and pulses done.
module icache_linefill_ctrl #(
    parameter int MSHR_ENTRY_NUM = 8,
    parameter int ENTRY_ID_W     = 3,
    parameter int WAY_NUM        = 4,
    parameter int INDEX_W        = 7,
    parameter int BEAT_W         = 128,
    parameter int BEATS_PER_LINE = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               txreq_vld,
    input  logic                               txreq_rdy,
    input  logic [ENTRY_ID_W-1:0]              txreq_entry_id,
    input  logic                               txreq_lineA,
    input  logic [INDEX_W-1:0]                 txreq_index,
    input  logic [WAY_NUM-1:0]                 txreq_way,
    input  logic                               rxdat_vld,
    output logic                               rxdat_rdy,
    input  logic [ENTRY_ID_W:0]                rxdat_txnid,
    input  logic [BEAT_W-1:0]                  rxdat_data,
    output logic                               dataram_wr_vld,
    input  logic                               dataram_wr_rdy,
    output logic [INDEX_W-1:0]                 dataram_wr_index,
    output logic [WAY_NUM-1:0]                 dataram_wr_way,
    output logic [BEAT_W*BEATS_PER_LINE-1:0]   dataram_wr_data,
    output logic [MSHR_ENTRY_NUM-1:0]          v_linefillA_done,
    output logic [MSHR_ENTRY_NUM-1:0]          v_linefillB_done,
    output logic                               busy,
    output logic                               err_orphan
);

    localparam int SLOT_NUM = 2 * MSHR_ENTRY_NUM;
    localparam int SLOT_W   = ENTRY_ID_W + 1;
    localparam int CNT_W    = $clog2(BEATS_PER_LINE);
    localparam int LINE_W   = BEAT_W * BEATS_PER_LINE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [SLOT_NUM-1:0] slot_vld;
    logic [INDEX_W-1:0]  slot_index [SLOT_NUM];
    logic [WAY_NUM-1:0]  slot_way   [SLOT_NUM];

    logic [CNT_W-1:0]    cnt_q;
    logic [SLOT_W-1:0]   cur_slot_q;
    logic [INDEX_W-1:0]  cur_index_q;
    logic [WAY_NUM-1:0]  cur_way_q;
    logic [LINE_W-1:0]   line_q;
    logic                err_q;

    logic                rdy_state;
    logic                beat_acc;
    logic                first_ok;
    logic                first_orphan;
    logic                collect_beat;
    logic                wr_hs;
    logic                cap;
    logic [SLOT_W-1:0]   cap_slot;
    logic [CNT_W-1:0]    wr_pos;

    assign rdy_state    = (state_q == S_IDLE) || (state_q == S_COLLECT);
    assign beat_acc     = rxdat_vld && rdy_state;
    assign first_ok     = (state_q == S_IDLE) && beat_acc && slot_vld[rxdat_txnid];
    assign first_orphan = (state_q == S_IDLE) && beat_acc && !slot_vld[rxdat_txnid];
    assign collect_beat = (state_q == S_COLLECT) && beat_acc;
    assign wr_hs        = (state_q == S_WRITE) && dataram_wr_rdy;
    assign cap          = txreq_vld && txreq_rdy;
    assign cap_slot     = {txreq_entry_id, txreq_lineA};
    assign wr_pos       = (state_q == S_IDLE) ? '0 : cnt_q;

    // ready is forced low while reset is asserted, even though the FSM already sits in IDLE
    assign rxdat_rdy        = rst_n && rdy_state;
    assign busy             = (state_q != S_IDLE);
    assign err_orphan       = err_q;
    assign dataram_wr_index = cur_index_q;
    assign dataram_wr_way   = cur_way_q;
    assign dataram_wr_data  = line_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        dataram_wr_vld = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (first_ok) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (collect_beat && (cnt_q == CNT_W'(BEATS_PER_LINE - 1))) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                dataram_wr_vld = 1'b1;
                if (dataram_wr_rdy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        v_linefillA_done = '0;
        v_linefillB_done = '0;
        if (state_q == S_DONE) begin
            if (cur_slot_q[0]) begin
                v_linefillA_done[cur_slot_q[SLOT_W-1:1]] = 1'b1;
            end else begin
                v_linefillB_done[cur_slot_q[SLOT_W-1:1]] = 1'b1;
            end
        end
    end

    // Capture is applied after the handshake clear so a same-slot capture wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld <= '0;
            err_q    <= 1'b0;
            for (int unsigned s = 0; s < SLOT_NUM; s++) begin
                slot_index[s] <= '0;
                slot_way[s]   <= '0;
            end
        end else begin
            if (wr_hs) begin
                slot_vld[cur_slot_q] <= 1'b0;
            end
            if (cap) begin
                slot_vld[cap_slot]   <= 1'b1;
                slot_index[cap_slot] <= txreq_index;
                slot_way[cap_slot]   <= txreq_way;
                if (slot_vld[cap_slot] && !(wr_hs && (cur_slot_q == cap_slot))) begin
                    err_q <= 1'b1;
                end
            end
            if (first_orphan) begin
                err_q <= 1'b1;
            end
        end
    end

    // Destination is latched with the first beat so later captures cannot disturb a held write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            cur_slot_q  <= '0;
            cur_index_q <= '0;
            cur_way_q   <= '0;
            line_q      <= '0;
        end else begin
            if (first_ok) begin
                cur_slot_q  <= rxdat_txnid;
                cur_index_q <= slot_index[rxdat_txnid];
                cur_way_q   <= slot_way[rxdat_txnid];
                cnt_q       <= CNT_W'(1);
            end else if (collect_beat) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (first_ok || collect_beat) begin
                for (int unsigned k = 0; k < BEATS_PER_LINE; k++) begin
                    if (wr_pos == CNT_W'(k)) begin
                        line_q[k*BEAT_W +: BEAT_W] <= rxdat_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_linefill_ctrl.sv
// Directed self-checking bench for icache_linefill_ctrl (default parameters).
module tb_icache_linefill_ctrl;

    logic         clk;
    logic         rst_n;
    logic         txreq_vld;
    logic         txreq_rdy;
    logic [2:0]   txreq_entry_id;
    logic         txreq_lineA;
    logic [6:0]   txreq_index;
    logic [3:0]   txreq_way;
    logic         rxdat_vld;
    logic         rxdat_rdy;
    logic [3:0]   rxdat_txnid;
    logic [127:0] rxdat_data;
    logic         dataram_wr_vld;
    logic         dataram_wr_rdy;
    logic [6:0]   dataram_wr_index;
    logic [3:0]   dataram_wr_way;
    logic [511:0] dataram_wr_data;
    logic [7:0]   v_linefillA_done;
    logic [7:0]   v_linefillB_done;
    logic         busy;
    logic         err_orphan;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [6:0]   wr_idx_q[$];
    logic [3:0]   wr_way_q[$];
    logic [511:0] wr_data_q[$];
    logic [15:0]  done_q[$];
    int           done_cyc_q[$];
    int           beat_cyc;
    int           multi_done;

    icache_linefill_ctrl #(
        .MSHR_ENTRY_NUM(8),
        .ENTRY_ID_W(3),
        .WAY_NUM(4),
        .INDEX_W(7),
        .BEAT_W(128),
        .BEATS_PER_LINE(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .txreq_vld(txreq_vld),
        .txreq_rdy(txreq_rdy),
        .txreq_entry_id(txreq_entry_id),
        .txreq_lineA(txreq_lineA),
        .txreq_index(txreq_index),
        .txreq_way(txreq_way),
        .rxdat_vld(rxdat_vld),
        .rxdat_rdy(rxdat_rdy),
        .rxdat_txnid(rxdat_txnid),
        .rxdat_data(rxdat_data),
        .dataram_wr_vld(dataram_wr_vld),
        .dataram_wr_rdy(dataram_wr_rdy),
        .dataram_wr_index(dataram_wr_index),
        .dataram_wr_way(dataram_wr_way),
        .dataram_wr_data(dataram_wr_data),
        .v_linefillA_done(v_linefillA_done),
        .v_linefillB_done(v_linefillB_done),
        .busy(busy),
        .err_orphan(err_orphan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change 1 time unit after posedge, so the negedge sees what the next edge will use.
    always @(negedge clk) begin
        if (dataram_wr_vld && dataram_wr_rdy) begin
            wr_idx_q.push_back(dataram_wr_index);
            wr_way_q.push_back(dataram_wr_way);
            wr_data_q.push_back(dataram_wr_data);
        end
        if (rxdat_vld && rxdat_rdy) beat_cyc = cyc;
        if ({v_linefillA_done, v_linefillB_done} != 16'h0) begin
            done_q.push_back({v_linefillA_done, v_linefillB_done});
            done_cyc_q.push_back(cyc);
        end
        if ($countones({v_linefillA_done, v_linefillB_done}) > 1) multi_done++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [511:0] mk_line(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
        return {{16{b3}}, {16{b2}}, {16{b1}}, {16{b0}}};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        wr_idx_q.delete();
        wr_way_q.delete();
        wr_data_q.delete();
        done_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic send_req(input logic [2:0] id, input logic la, input logic [6:0] idx,
                            input logic [3:0] way);
        txreq_vld      = 1'b1;
        txreq_rdy      = 1'b1;
        txreq_entry_id = id;
        txreq_lineA    = la;
        txreq_index    = idx;
        txreq_way      = way;
        tick(1);
        txreq_vld = 1'b0;
    endtask

    task automatic send_beat(input logic [3:0] id, input logic [127:0] d);
        bit ok;
        ok          = 1'b0;
        rxdat_vld   = 1'b1;
        rxdat_txnid = id;
        rxdat_data  = d;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (rxdat_rdy === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        rxdat_vld = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL beat_accept: txnid=%0d not accepted, required acceptance within 60 cycles", id);
        end
    endtask

    task automatic send_line(input logic [3:0] id, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        send_beat(id, {16{b0}});
        send_beat(id, {16{b1}});
        send_beat(id, {16{b2}});
        send_beat(id, {16{b3}});
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (rxdat_rdy !== 1'b0 || dataram_wr_vld !== 1'b0 || busy !== 1'b0 || err_orphan !== 1'b0 ||
            v_linefillA_done !== 8'h0 || v_linefillB_done !== 8'h0 || dataram_wr_index !== 7'h0 ||
            dataram_wr_way !== 4'h0 || dataram_wr_data !== 512'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b wr_vld=%b busy=%b err=%b A=%h B=%h, required all 0",
                     rxdat_rdy, dataram_wr_vld, busy, err_orphan, v_linefillA_done, v_linefillB_done);
        end
        tick(2);
        rst_n = 1'b1;
        #1;
        checks++;
        if (rxdat_rdy !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b busy=%b, required rdy=1 busy=0", rxdat_rdy, busy);
        end
        tick(1);
    endtask

    task automatic test_basic_a();
        clear_log();
        send_req(3'd2, 1'b1, 7'h15, 4'b0100);
        send_line(4'd5, 8'h11, 8'h22, 8'h33, 8'h44);
        tick(5);
        checks++;
        if (wr_idx_q.size() != 1) begin
            errors++;
            $display("FAIL basic_wr_count: got %0d writes, required 1", wr_idx_q.size());
        end else begin
            checks++;
            if (wr_idx_q[0] !== 7'h15 || wr_way_q[0] !== 4'b0100) begin
                errors++;
                $display("FAIL basic_wr_dest: idx=%h way=%b, required idx=15 way=0100", wr_idx_q[0], wr_way_q[0]);
            end
            checks++;
            if (wr_data_q[0] !== mk_line(8'h11, 8'h22, 8'h33, 8'h44)) begin
                errors++;
                $display("FAIL basic_wr_data: got %h, required %h", wr_data_q[0], mk_line(8'h11, 8'h22, 8'h33, 8'h44));
            end
        end
        checks++;
        if (done_q.size() != 1) begin
            errors++;
            $display("FAIL basic_done_count: got %0d pulse cycles, required 1", done_q.size());
        end else begin
            checks++;
            if (done_q[0] !== {8'h04, 8'h00}) begin
                errors++;
                $display("FAIL basic_done_vec: A/B=%h, required 0400", done_q[0]);
            end
            checks++;
            if (done_cyc_q[0] - beat_cyc != 2) begin
                errors++;
                $display("FAIL basic_latency: %0d cycles after last beat, required 2", done_cyc_q[0] - beat_cyc);
            end
        end
        checks++;
        if (busy !== 1'b0 || err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: busy=%b err=%b, required 0 0", busy, err_orphan);
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_req(3'd5, 1'b1, 7'h10, 4'b0001);
        send_req(3'd5, 1'b0, 7'h11, 4'b0010);
        send_line(4'd11, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
        send_line(4'd10, 8'hB0, 8'hB1, 8'hB2, 8'hB3);
        tick(5);
        checks++;
        if (wr_idx_q.size() != 2 || done_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: writes=%0d pulses=%0d, required 2 and 2", wr_idx_q.size(), done_q.size());
        end else begin
            checks++;
            if (wr_idx_q[0] !== 7'h10 || wr_idx_q[1] !== 7'h11 || wr_way_q[1] !== 4'b0010) begin
                errors++;
                $display("FAIL b2b_dest: idx0=%h idx1=%h way1=%b, required 10 11 0010", wr_idx_q[0], wr_idx_q[1], wr_way_q[1]);
            end
            checks++;
            if (wr_data_q[1] !== mk_line(8'hB0, 8'hB1, 8'hB2, 8'hB3)) begin
                errors++;
                $display("FAIL b2b_data: got %h, required %h", wr_data_q[1], mk_line(8'hB0, 8'hB1, 8'hB2, 8'hB3));
            end
            checks++;
            if (done_q[0] !== {8'h20, 8'h00} || done_q[1] !== {8'h00, 8'h20}) begin
                errors++;
                $display("FAIL b2b_done: first=%h second=%h, required 2000 then 0020", done_q[0], done_q[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [511:0] exp_a;
        exp_a = mk_line(8'hC0, 8'hC1, 8'hC2, 8'hC3);
        clear_log();
        send_req(3'd0, 1'b1, 7'h2A, 4'b1000);
        send_req(3'd0, 1'b0, 7'h2B, 4'b0001);
        dataram_wr_rdy = 1'b0;
        send_line(4'd1, 8'hC0, 8'hC1, 8'hC2, 8'hC3);
        rxdat_vld   = 1'b1;
        rxdat_txnid = 4'd0;
        rxdat_data  = {16{8'hD0}};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dataram_wr_vld !== 1'b1 || dataram_wr_index !== 7'h2A || dataram_wr_way !== 4'b1000 ||
                dataram_wr_data !== exp_a || rxdat_rdy !== 1'b0 || v_linefillA_done !== 8'h0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: vld=%b idx=%h way=%b rdy=%b A=%h, required 1 2a 1000 0 00 and line held",
                         i, dataram_wr_vld, dataram_wr_index, dataram_wr_way, rxdat_rdy, v_linefillA_done);
            end
            tick(1);
        end
        checks++;
        if (wr_idx_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL bp_early: writes=%0d pulses=%0d before handshake, required 0 0", wr_idx_q.size(), done_q.size());
        end
        dataram_wr_rdy = 1'b1;
        send_line(4'd0, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
        tick(5);
        checks++;
        if (wr_idx_q.size() != 2 || done_q.size() != 2) begin
            errors++;
            $display("FAIL bp_count: writes=%0d pulses=%0d, required 2 and 2", wr_idx_q.size(), done_q.size());
        end else begin
            checks++;
            if (wr_idx_q[1] !== 7'h2B || wr_data_q[1] !== mk_line(8'hD0, 8'hD1, 8'hD2, 8'hD3) ||
                done_q[0] !== {8'h01, 8'h00} || done_q[1] !== {8'h00, 8'h01}) begin
                errors++;
                $display("FAIL bp_result: idx1=%h done0=%h done1=%h, required 2b 0100 0001 and stalled line intact",
                         wr_idx_q[1], done_q[0], done_q[1]);
            end
        end
    endtask

    task automatic test_orphan();
        clear_log();
        checks++;
        if (err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL orphan_pre: err=%b, required 0", err_orphan);
        end
        send_beat(4'd7, {16{8'hEE}});
        checks++;
        if (err_orphan !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL orphan_flag: err=%b busy=%b, required 1 0", err_orphan, busy);
        end
        tick(6);
        checks++;
        if (err_orphan !== 1'b1 || wr_idx_q.size() != 0 || done_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL orphan_after: err=%b writes=%0d pulses=%0d busy=%b, required 1 0 0 0",
                     err_orphan, wr_idx_q.size(), done_q.size(), busy);
        end
    endtask

    task automatic test_reset_mid_line();
        clear_log();
        send_req(3'd6, 1'b1, 7'h33, 4'b0010);
        send_beat(4'd13, {16{8'h51}});
        send_beat(4'd13, {16{8'h52}});
        rst_n = 1'b0;
        #2;
        checks++;
        if (rxdat_rdy !== 1'b0 || dataram_wr_vld !== 1'b0 || busy !== 1'b0 || err_orphan !== 1'b0 ||
            v_linefillA_done !== 8'h0 || dataram_wr_data !== 512'h0) begin
            errors++;
            $display("FAIL midreset_outputs: rdy=%b wr_vld=%b busy=%b err=%b, required all 0",
                     rxdat_rdy, dataram_wr_vld, busy, err_orphan);
        end
        tick(2);
        rst_n = 1'b1;
        tick(1);
        send_beat(4'd13, {16{8'h53}});
        checks++;
        if (err_orphan !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_table: err=%b busy=%b, required 1 0 (slot cleared by reset)", err_orphan, busy);
        end
        send_req(3'd6, 1'b1, 7'h34, 4'b0100);
        send_line(4'd13, 8'h61, 8'h62, 8'h63, 8'h64);
        tick(5);
        checks++;
        if (wr_idx_q.size() != 1 || done_q.size() != 1) begin
            errors++;
            $display("FAIL midreset_count: writes=%0d pulses=%0d, required 1 1", wr_idx_q.size(), done_q.size());
        end else begin
            checks++;
            if (wr_idx_q[0] !== 7'h34 || wr_way_q[0] !== 4'b0100 ||
                wr_data_q[0] !== mk_line(8'h61, 8'h62, 8'h63, 8'h64) || done_q[0] !== {8'h40, 8'h00}) begin
                errors++;
                $display("FAIL midreset_fresh: idx=%h way=%b done=%h, required 34 0100 4000 and fresh data",
                         wr_idx_q[0], wr_way_q[0], done_q[0]);
            end
        end
    endtask

    task automatic test_collision();
        clear_log();
        send_req(3'd1, 1'b1, 7'h05, 4'b0001);
        dataram_wr_rdy = 1'b0;
        send_line(4'd3, 8'h71, 8'h72, 8'h73, 8'h74);
        tick(1);
        checks++;
        if (dataram_wr_vld !== 1'b1) begin
            errors++;
            $display("FAIL coll_write_pending: wr_vld=%b, required 1", dataram_wr_vld);
        end
        dataram_wr_rdy = 1'b1;
        send_req(3'd1, 1'b1, 7'h06, 4'b1000);
        tick(3);
        send_line(4'd3, 8'h81, 8'h82, 8'h83, 8'h84);
        tick(5);
        checks++;
        if (wr_idx_q.size() != 2 || done_q.size() != 2) begin
            errors++;
            $display("FAIL coll_count: writes=%0d pulses=%0d, required 2 2", wr_idx_q.size(), done_q.size());
        end else begin
            checks++;
            if (wr_idx_q[0] !== 7'h05 || wr_idx_q[1] !== 7'h06 || wr_way_q[1] !== 4'b1000 ||
                wr_data_q[1] !== mk_line(8'h81, 8'h82, 8'h83, 8'h84)) begin
                errors++;
                $display("FAIL coll_dest: idx0=%h idx1=%h way1=%b, required 05 06 1000",
                         wr_idx_q[0], wr_idx_q[1], wr_way_q[1]);
            end
            checks++;
            if (done_q[0] !== {8'h02, 8'h00} || done_q[1] !== {8'h02, 8'h00}) begin
                errors++;
                $display("FAIL coll_done: done0=%h done1=%h, required 0200 0200", done_q[0], done_q[1]);
            end
        end
    endtask

    task automatic test_done_onehot();
        checks++;
        if (multi_done != 0) begin
            errors++;
            $display("FAIL done_onehot: %0d cycles with multiple done bits, required 0", multi_done);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        txreq_vld      = 1'b0;
        txreq_rdy      = 1'b0;
        txreq_entry_id = '0;
        txreq_lineA    = 1'b0;
        txreq_index    = '0;
        txreq_way      = '0;
        rxdat_vld      = 1'b0;
        rxdat_txnid    = '0;
        rxdat_data     = '0;
        dataram_wr_rdy = 1'b1;
        beat_cyc       = 0;
        multi_done     = 0;

        test_reset();
        test_basic_a();
        test_back_to_back();
        test_backpressure();
        test_orphan();
        test_reset_mid_line();
        test_collision();
        test_done_onehot();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
